// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the load path: funct3 codes, the load-unit
// state encoding and the request legality check.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } ld_state_t;

  // True when the request must be answered with an error and no memory access:
  // unknown funct3, or a halfword/word that does not sit on its natural boundary.
  function automatic logic ld_bad(input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    case (f3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = a[0];
      F3_LW:         bad = (a != 2'b00);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// Request, data-memory and response signals of the load unit.
// The slave side is the load unit; the master side is execute stage + memory.
interface load_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_funct3, req_addr, mem_rvalid, mem_rdata, rsp_ready,
    output req_ready, mem_re, mem_addr, rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_funct3, req_addr, mem_rvalid, mem_rdata, rsp_ready,
    input  req_ready, mem_re, mem_addr, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/load_ext.sv
// Lane select and sign/zero extension of a little-endian memory word.
module load_ext
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed lane, then extend according to the load type.
  always_comb begin
    byte_v = rdata[7:0];
    case (addr_lo)
      2'd0: byte_v = rdata[7:0];
      2'd1: byte_v = rdata[15:8];
      2'd2: byte_v = rdata[23:16];
      2'd3: byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   result = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  result = {24'h0, byte_v};
      F3_LH:   result = {{16{half_v[15]}}, half_v};
      F3_LHU:  result = {16'h0, half_v};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Single-outstanding data-memory load sequencer: check, one word read, wait
// for data (with optional timeout), extend, and hold the result until taken.
module load_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  load_unit_if.slave  bus
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  ld_state_t   state;
  logic [2:0]  f3_q;
  logic [1:0]  addr_lo_q;
  logic [CW-1:0] cnt;
  logic [31:0] ext_data;

  load_ext u_ext (
    .rdata   (bus.mem_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (f3_q),
    .result  (ext_data)
  );

  // Load FSM; every handshake and memory output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      f3_q          <= 3'b000;
      addr_lo_q     <= 2'b00;
      cnt           <= '0;
      bus.req_ready <= 1'b1;
      bus.mem_re    <= 1'b0;
      bus.mem_addr  <= 32'h0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= 32'h0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            f3_q          <= bus.req_funct3;
            addr_lo_q     <= bus.req_addr[1:0];
            bus.req_ready <= 1'b0;
            if (ld_bad(bus.req_funct3, bus.req_addr[1:0])) begin
              // Rejected requests never touch memory.
              state         <= S_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_data  <= 32'h0;
            end else begin
              state        <= S_READ;
              bus.mem_re   <= 1'b1;
              bus.mem_addr <= {bus.req_addr[31:2], 2'b00};
            end
          end
        end
        S_READ: begin
          // Strobe and address are up for this cycle only.
          bus.mem_re   <= 1'b0;
          bus.mem_addr <= 32'h0;
          cnt          <= '0;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mem_rvalid) begin
            bus.rsp_data  <= ext_data;
            bus.rsp_err   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            state         <= S_RESP;
          end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
            bus.rsp_data  <= 32'h0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_valid <= 1'b1;
            state         <= S_RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: begin
          state         <= S_IDLE;
          bus.req_ready <= 1'b1;
          bus.rsp_valid <= 1'b0;
          bus.mem_re    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: vector table for the single-load paths plus
// hand-written timeout, back-pressure and reset-abort sequences.
module tb_load_unit;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_unit_if bus ();

  load_unit #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp_maddr;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t vt[14];
  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Pop the oldest expected response and compare against the live outputs.
  task automatic sb_check(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      ncmp++;
      nfail++;
      $display("FAIL %s: response with empty scoreboard got 1 want 0", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, ".data"}, bus.rsp_data, e.data);
      chk({nm, ".err"}, {31'h0, bus.rsp_err}, {31'h0, e.err});
    end
  endtask

  task automatic handshake(input string nm);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({nm, ".vld_clr"}, {31'h0, bus.rsp_valid}, 32'h0);
    chk({nm, ".rdy_back"}, {31'h0, bus.req_ready}, 32'h1);
  endtask

  // One load from the table, memory answering the cycle after mem_re.
  task automatic run_vec(input int i);
    vec_t v;
    string nm;
    exp_t e;
    v = vt[i];
    nm = $sformatf("vec%0d", i);
    chk({nm, ".req_ready"}, {31'h0, bus.req_ready}, 32'h1);
    bus.req_valid = 1'b1;
    bus.req_funct3 = v.f3;
    bus.req_addr = v.addr;
    e.data = v.exp_data;
    e.err = v.exp_err;
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (!v.exp_err) begin
      chk({nm, ".mem_re"}, {31'h0, bus.mem_re}, 32'h1);
      chk({nm, ".mem_addr"}, bus.mem_addr, v.exp_maddr);
      @(negedge clk);
      chk({nm, ".mem_re_off"}, {31'h0, bus.mem_re}, 32'h0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = v.rdata;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata = $urandom;
    end else begin
      chk({nm, ".no_mem_re"}, {31'h0, bus.mem_re}, 32'h0);
    end
    chk({nm, ".rsp_valid"}, {31'h0, bus.rsp_valid}, 32'h1);
    sb_check(nm);
    handshake(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_t e;

    vt[0]  = '{F3_LB,  32'h103, 32'h80FF_1234, 32'h100, 32'hFFFF_FF80, 1'b0};
    vt[1]  = '{F3_LBU, 32'h102, 32'h9ABC_5678, 32'h100, 32'h0000_00BC, 1'b0};
    vt[2]  = '{F3_LHU, 32'h102, 32'h9ABC_5678, 32'h100, 32'h0000_9ABC, 1'b0};
    vt[3]  = '{F3_LH,  32'h102, 32'h9ABC_5678, 32'h100, 32'hFFFF_9ABC, 1'b0};
    vt[4]  = '{F3_LW,  32'h204, 32'hDEAD_BEEF, 32'h204, 32'hDEAD_BEEF, 1'b0};
    vt[5]  = '{F3_LB,  32'h300, 32'h1234_5678, 32'h300, 32'h0000_0078, 1'b0};
    vt[6]  = '{F3_LH,  32'h300, 32'h1234_F678, 32'h300, 32'hFFFF_F678, 1'b0};
    vt[7]  = '{F3_LBU, 32'h001, 32'h0000_A500, 32'h000, 32'h0000_00A5, 1'b0};
    vt[8]  = '{F3_LW,  32'h201, 32'h0,         32'h0,   32'h0,         1'b1};
    vt[9]  = '{F3_LH,  32'h203, 32'h0,         32'h0,   32'h0,         1'b1};
    vt[10] = '{3'b011, 32'h100, 32'h0,         32'h0,   32'h0,         1'b1};
    vt[11] = '{3'b110, 32'h100, 32'h0,         32'h0,   32'h0,         1'b1};
    vt[12] = '{3'b111, 32'h100, 32'h0,         32'h0,   32'h0,         1'b1};
    vt[13] = '{F3_LHU, 32'h005, 32'h0,         32'h0,   32'h0,         1'b1};

    bus.req_valid = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = 32'h0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst.mem_re", {31'h0, bus.mem_re}, 32'h0);
    chk("rst.mem_addr", bus.mem_addr, 32'h0);
    chk("rst.rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst.rsp_data", bus.rsp_data, 32'h0);
    chk("rst.rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_vec(i);

    // Timeout: no data ever returns; error at T+18 (READ + 16 WAIT cycles).
    bus.req_valid = 1'b1;
    bus.req_funct3 = F3_LW;
    bus.req_addr = 32'h400;
    e.data = 32'h0;
    e.err = 1'b1;
    sb.push_back(e);
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      n++;
      if (bus.rsp_valid) break;
    end
    chk("to.latency", n, 32'd18);
    if (bus.rsp_valid) sb_check("to");
    else begin
      void'(sb.pop_front());
      ncmp++;
      nfail++;
      $display("FAIL to.rsp_valid: got 0 want 1");
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    repeat (2) begin
      @(negedge clk);
      chk("to.late_data", bus.rsp_data, 32'h0);
      chk("to.late_err", {31'h0, bus.rsp_err}, 32'h1);
    end
    handshake("to");
    repeat (2) begin
      @(negedge clk);
      chk("to.idle_vld", {31'h0, bus.rsp_valid}, 32'h0);
      chk("to.idle_mem_re", {31'h0, bus.mem_re}, 32'h0);
      chk("to.idle_data", bus.rsp_data, 32'h0);
    end
    bus.mem_rvalid = 1'b0;

    // Back-pressure: response held 5 cycles while a new request waits.
    bus.req_valid = 1'b1;
    bus.req_funct3 = F3_LW;
    bus.req_addr = 32'h500;
    e.data = 32'h1357_9BDF;
    e.err = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("bp.mem_re", {31'h0, bus.mem_re}, 32'h1);
    @(negedge clk);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h1357_9BDF;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    chk("bp.rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
    sb_check("bp");
    bus.req_valid = 1'b1;
    bus.req_funct3 = 3'b111;
    bus.req_addr = 32'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp.hold_vld", {31'h0, bus.rsp_valid}, 32'h1);
      chk("bp.hold_data", bus.rsp_data, 32'h1357_9BDF);
      chk("bp.hold_err", {31'h0, bus.rsp_err}, 32'h0);
      chk("bp.hold_rdy", {31'h0, bus.req_ready}, 32'h0);
      chk("bp.hold_mem_re", {31'h0, bus.mem_re}, 32'h0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("bp.rdy_after", {31'h0, bus.req_ready}, 32'h1);
    chk("bp.vld_after", {31'h0, bus.rsp_valid}, 32'h0);
    e.data = 32'h0;
    e.err = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("bp2.rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
    sb_check("bp2");
    handshake("bp2");

    // Reset during WAIT aborts the load; later data is ignored.
    bus.req_valid = 1'b1;
    bus.req_funct3 = F3_LB;
    bus.req_addr = 32'h600;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ar.req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("ar.mem_re", {31'h0, bus.mem_re}, 32'h0);
    chk("ar.mem_addr", bus.mem_addr, 32'h0);
    chk("ar.rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("ar.rsp_data", bus.rsp_data, 32'h0);
    chk("ar.rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    repeat (3) begin
      @(negedge clk);
      chk("ar.no_rsp", {31'h0, bus.rsp_valid}, 32'h0);
      chk("ar.ready", {31'h0, bus.req_ready}, 32'h1);
    end
    bus.mem_rvalid = 1'b0;

    chk("sb.empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
